// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// It performs one shift-add multiply step or one restoring-divide step per cycle on operand magnitudes.
// Sign correction and the divide-by-zero result are applied when the result is written back.
module muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            opcode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    // opcode bit 1 selects divide; bit 0 selects unsigned
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      op_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [2*W-1:0]  work_reg, work_next;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    hi_reg, lo_reg;
    logic            done_reg;

    logic            accept, iterate, finish;

    // Magnitudes of the incoming operands, used to seed the work register
    logic            in_signed;
    logic [W-1:0]    in_mag_a, in_mag_b;
    assign in_signed = (opcode == MD_MULT) || (opcode == MD_DIV);
    assign in_mag_a  = (in_signed && a[W-1]) ? -a : a;
    assign in_mag_b  = (in_signed && b[W-1]) ? -b : b;

    // Magnitudes and sign flags of the latched operands
    logic            op_signed, a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;
    assign op_signed = (op_reg == MD_MULT) || (op_reg == MD_DIV);
    assign a_neg     = op_signed && a_reg[W-1];
    assign b_neg     = op_signed && b_reg[W-1];
    assign mag_a     = a_neg ? -a_reg : a_reg;
    assign mag_b     = b_neg ? -b_reg : b_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: RUN lasts exactly W cycles, DONE lasts one
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == CW'(W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        busy    = (state_reg != IDLE);
        accept  = (state_reg == IDLE) && start;
        iterate = (state_reg == RUN);
        finish  = (state_reg == DONE);
    end

    // One iteration step: multiply adds mag_a into the upper half and shifts right.
    // Divide shifts left and subtracts the divisor when the trial remainder stays non-negative.
    logic [W:0] sum, shifted, trial;
    always_comb begin
        sum     = {1'b0, work_reg[2*W-1:W]} + (work_reg[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
        shifted = work_reg[2*W-1:W-1];
        trial   = shifted - {1'b0, mag_b};
        if (op_reg[1]) begin
            if (!trial[W]) work_next = {trial[W-1:0], work_reg[W-2:0], 1'b1};
            else           work_next = {work_reg[2*W-2:0], 1'b0};
        end else begin
            work_next = {sum, work_reg[W-1:1]};
        end
    end

    // Sign-corrected result; a zero divisor yields all-ones quotient and the raw dividend
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, res_hi, res_lo;
    always_comb begin
        prod = (a_neg ^ b_neg) ? -work_reg : work_reg;
        quo  = work_reg[W-1:0];
        rem  = work_reg[2*W-1:W];
        if (op_reg[1]) begin
            if (b_reg == '0) begin
                res_hi = a_reg;
                res_lo = '1;
            end else begin
                res_lo = (a_neg ^ b_neg) ? -quo : quo;
                res_hi = a_neg ? -rem : rem;
            end
        end else begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end
    end

    // Operand latch, iteration, result write-back and direct HI/LO writes
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg   <= MD_MULT;
            a_reg    <= '0;
            b_reg    <= '0;
            work_reg <= '0;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                op_reg   <= opcode;
                a_reg    <= a;
                b_reg    <= b;
                cnt_reg  <= '0;
                work_reg <= {{W{1'b0}}, (opcode[1] ? in_mag_a : in_mag_b)};
            end else if (iterate) begin
                work_reg <= work_next;
                cnt_reg  <= cnt_reg + CW'(1);
            end
            if (finish) begin
                hi_reg   <= res_hi;
                lo_reg   <= res_lo;
                done_reg <= 1'b1;
            end
            if ((state_reg == IDLE) && !start) begin
                if (hi_we) hi_reg <= wdata;
                if (lo_we) lo_reg <= wdata;
            end
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: tb/tb_muldiv.sv
// Directed testbench for muldiv with hand-computed results.
module tb_muldiv;
    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we, busy, done;
    logic [1:0]  opcode;
    logic [31:0] a, b, wdata, hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check the result and the end of busy.
    // With inject set, a second start plus hi_we is pulsed at cycle 10 of the run.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input bit inject);
        int lat;
        logic [31:0] prev_hi;
        prev_hi = hi;
        opcode = op; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0; opcode = op ^ 2'b01;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (i == 1)  check({tag, "_busy"}, busy, 1'b1);
            if (i == 10) check({tag, "_hold"}, hi, prev_hi);
            if (inject) begin
                if (i == 10) begin
                    start = 1'b1; hi_we = 1'b1; wdata = 32'h1234; opcode = 2'd0; a = 32'h7; b = 32'h9;
                end else begin
                    start = 1'b0; hi_we = 1'b0;
                end
            end
        end
        check({tag, "_lat"}, lat, 33);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        $display("op %s opcode=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", tag, op, av, bv, hi, lo, lat);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, done, 1'b0);
        check({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        opcode = 2'd0; a = 32'h0; b = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // Direct writes in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hAAAA5555);
        check("mthi_lo", lo, 32'h0);
        lo_we = 1'b1; wdata = 32'h00001111;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h00001111);
        check("mtlo_hi", hi, 32'hAAAA5555);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00002222;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", hi, 32'h00002222);
        check("mtboth_lo", lo, 32'h00002222);
        $display("direct writes hi=%h lo=%h", hi, lo);

        run_op("mult_neg",    2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("mult_negneg", 2'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0);
        run_op("multu_max",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div_m7_2",    2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7_m2",    2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",     2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_zero",   2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b0);
        run_op("div_zero",    2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        run_op("multu_inj",   2'd1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b1);
        run_op("divu_big",    2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0);

        // Abort a DIVU with reset at cycle 5, then start again immediately
        opcode = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        $display("abort busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        run_op("divu_after_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port opcode, input, 2 bits: `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3 (defines.vh).
REQ-006 SHALL have ports a and b, input, DATA_WIDTH each: a is multiplicand/dividend, b is multiplier/divisor.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 bit each: direct write strobes (mthi/mtlo).
REQ-008 SHALL have port wdata, input, DATA_WIDTH: direct write data.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when hi and lo take a new result.
REQ-011 SHALL have ports hi and lo, output, DATA_WIDTH each: the registered HI and LO values.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE: latch opcode, a and b, clear the iteration counter, and move to RUN; later changes on a, b or opcode have no effect.
REQ-014 SHALL ignore start in RUN and DONE, with no queueing.
REQ-015 SHALL spend exactly DATA_WIDTH cycles in RUN, one iteration per cycle (shift-add multiply, restoring divide on magnitudes), then move to DONE.
REQ-016 SHALL, in DONE, write hi and lo, assert done for that cycle only, and return to IDLE on the next cycle.
REQ-017 SHALL have fixed latency: accepted start at edge N gives done=1 and new hi/lo in the cycle after edge N+DATA_WIDTH+1.
REQ-018 SHALL drive busy=1 in RUN and DONE and busy=0 in IDLE.
REQ-019 SHALL, for MULT/MULTU, set {hi,lo} to the full 2*DATA_WIDTH-bit signed/unsigned product.
REQ-020 SHALL, for DIV/DIVU, set lo to the quotient and hi to the remainder.
REQ-021 SHALL, for signed divide, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-022 SHALL, for divide by zero (any division), set lo to all ones and hi to a; no exception is raised.
REQ-023 SHALL, for DIV of the most negative value by -1, set lo to the most negative value and hi to 0.
REQ-024 SHALL, in IDLE only, load wdata into hi on hi_we=1 and into lo on lo_we=1; both strobes may be set together.
REQ-025 SHALL ignore hi_we and lo_we in RUN and DONE, and in the cycle a start is accepted (start wins).
REQ-026 SHALL hold hi and lo unchanged between writes; reading during RUN returns the previous values.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE and clear hi, lo, busy, done, the counter and the latched operands to 0.
REQ-028 SHALL let rst during RUN or DONE abort the operation, with no done pulse and hi/lo cleared.
REQ-029 SHALL give rst priority over start, hi_we and lo_we in the same cycle.

Verification
REQ-030 SHALL cover: MULT a=0xFFFFFFFD, b=5 -> done at start+33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 SHALL cover: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL cover: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-034 SHALL cover: a second start and hi_we=1 (wdata=0x1234) pulsed at cycle 10 of a MULTU 3*4 -> ignored; single done pulse, hi=0, lo=12, busy low the cycle after done.
REQ-035 SHALL cover: rst=1 at cycle 5 of a DIVU -> busy=0 next cycle, no done, hi=lo=0; a new start is accepted on the following cycle.
